// File: rtl/toy_host_caller_pkg.sv
// -----------------------------------------------------------------------------
// toy_host_caller_pkg
// Shared definitions for the toy kernel host caller:
//   - state_e     : caller FSM states, one-hot like the generated kernel FSMs
//   - CNT_W_DEF   : default width of the invocation count
//   - CYC_W_DEF   : default width of the saturating elapsed-cycle counter
// -----------------------------------------------------------------------------
package toy_host_caller_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int CYC_W_DEF = 32;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        WAIT  = 4'b0100,
        RESP  = 4'b1000
    } state_e;

endpackage

// File: rtl/toy_host_caller_if.sv
// -----------------------------------------------------------------------------
// toy_host_caller_if
// Bundles the host command port, the kernel start/finish handshake and the
// response port of toy_host_caller.
//   master : host + kernel side (drives call_*, done_ready, callee_stall, finish)
//   slave  : the caller block itself
// With TOY_HOST_CALLER_WATCHDOG_EN defined an extra done_timeout signal exists.
// -----------------------------------------------------------------------------
interface toy_host_caller_if
    import toy_host_caller_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int CYC_W = CYC_W_DEF
);
    logic             call_valid;
    logic             call_ready;
    logic [CNT_W-1:0] call_count;
    logic             start;
    logic             callee_stall;
    logic             finish;
    logic             done_valid;
    logic             done_ready;
    logic [CNT_W-1:0] done_runs;
    logic [CYC_W-1:0] done_cycles;
    logic             proto_err;
`ifdef TOY_HOST_CALLER_WATCHDOG_EN
    logic             done_timeout;

    modport master (
        output call_valid, call_count, callee_stall, finish, done_ready,
        input  call_ready, start, done_valid, done_runs, done_cycles, proto_err,
               done_timeout
    );

    modport slave (
        input  call_valid, call_count, callee_stall, finish, done_ready,
        output call_ready, start, done_valid, done_runs, done_cycles, proto_err,
               done_timeout
    );
`else
    modport master (
        output call_valid, call_count, callee_stall, finish, done_ready,
        input  call_ready, start, done_valid, done_runs, done_cycles, proto_err
    );

    modport slave (
        input  call_valid, call_count, callee_stall, finish, done_ready,
        output call_ready, start, done_valid, done_runs, done_cycles, proto_err
    );
`endif
endinterface

// File: rtl/toy_sat_counter.sv
// -----------------------------------------------------------------------------
// toy_sat_counter
// Saturating up-counter with synchronous clear and count enable.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : zero the count (wins over enable)
//   enable       : advance by one, sticking at all-ones
//   count        : registered count value
// -----------------------------------------------------------------------------
module toy_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);
    logic [W-1:0] count_r;
    logic [W-1:0] count_inc_s;

    // Saturated successor of the current count
    always_comb begin
        if (count_r == {W{1'b1}}) begin
            count_inc_s = count_r;
        end else begin
            count_inc_s = count_r + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {W{1'b0}};
        end else if (clear) begin
            count_r <= {W{1'b0}};
        end else if (enable) begin
            count_r <= count_inc_s;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/toy_host_caller.sv
// -----------------------------------------------------------------------------
// toy_host_caller
// Host-side initiator for a toy kernel FSM. A command (call_count = N) is
// accepted in IDLE; the kernel is then started N times back to back, each run
// ending on a finish rising edge. The response reports runs completed and the
// number of START/WAIT cycles spent (saturating).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : call_valid/call_ready/call_count, start/callee_stall/finish,
//                  done_valid/done_ready/done_runs/done_cycles, proto_err
// Optional: TOY_HOST_CALLER_WATCHDOG_EN adds a per-run timer (TIMEOUT_CYC WAIT
// cycles) that aborts to RESP with done_timeout=1 and sets proto_err.
// -----------------------------------------------------------------------------
module toy_host_caller
    import toy_host_caller_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int CYC_W = CYC_W_DEF
`ifdef TOY_HOST_CALLER_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    toy_host_caller_if.slave bus
);
    state_e           state_r;
    state_e           next_s;
    logic [CNT_W-1:0] n_r;
    logic [CNT_W-1:0] runs_r;
    logic             finish_q_r;
    logic             start_r;
    logic             done_valid_r;
    logic             proto_err_r;
    logic [CYC_W-1:0] cyc_cnt_s;

    logic cmd_s;
    logic rise_s;
    logic accept_s;
    logic last_s;
    logic timeout_s;
    logic set_err_s;
    logic cyc_en_s;

    assign cmd_s    = (state_r == IDLE) && bus.call_valid;
    assign rise_s   = bus.finish && !finish_q_r;
    assign accept_s = (state_r == START) && start_r && !bus.callee_stall;
    assign last_s   = ((runs_r + CNT_W'(1)) == n_r);
    assign cyc_en_s = (state_r == START) || (state_r == WAIT);

    // Elapsed cycles; holds in RESP so it doubles as the done_cycles register
    toy_sat_counter #(.W(CYC_W)) u_cyc (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cmd_s),
        .enable  (cyc_en_s),
        .count   (cyc_cnt_s)
    );

`ifdef TOY_HOST_CALLER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

    logic [WD_W-1:0] wd_cnt_s;
    logic            done_timeout_r;

    // Per-run timer, restarted at every start accept, running only in WAIT
    toy_sat_counter #(.W(WD_W)) u_wd (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept_s),
        .enable  (state_r == WAIT),
        .count   (wd_cnt_s)
    );

    // Timer holds k-1 during the k-th WAIT cycle, so this fires on WAIT cycle TIMEOUT_CYC
    assign timeout_s = (state_r == WAIT) && (wd_cnt_s >= WD_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state decode and protocol-error detection
    always_comb begin
        next_s    = state_r;
        set_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                set_err_s = rise_s;
                if (cmd_s) begin
                    if (bus.call_count == {CNT_W{1'b0}}) begin
                        next_s = RESP;
                    end else begin
                        next_s = START;
                    end
                end else begin
                    next_s = IDLE;
                end
            end
            START: begin
                set_err_s = rise_s;
                if (accept_s) begin
                    next_s = WAIT;
                end else begin
                    next_s = START;
                end
            end
            WAIT: begin
                if (rise_s) begin
                    if (last_s) begin
                        next_s = RESP;
                    end else begin
                        next_s = START;
                    end
                end else if (timeout_s) begin
                    next_s    = RESP;
                    set_err_s = 1'b1;
                end else begin
                    next_s = WAIT;
                end
            end
            RESP: begin
                set_err_s = rise_s;
                if (bus.done_ready) begin
                    next_s = IDLE;
                end else begin
                    next_s = RESP;
                end
            end
            default: begin
                next_s    = IDLE;
                set_err_s = 1'b0;
            end
        endcase
    end

    // State, registered outputs, run bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            finish_q_r   <= 1'b0;
            start_r      <= 1'b0;
            done_valid_r <= 1'b0;
            proto_err_r  <= 1'b0;
            n_r          <= {CNT_W{1'b0}};
            runs_r       <= {CNT_W{1'b0}};
        end else begin
            state_r      <= next_s;
            finish_q_r   <= bus.finish;
            start_r      <= (next_s == START);
            done_valid_r <= (next_s == RESP);
            proto_err_r  <= proto_err_r | set_err_s;
            if (cmd_s) begin
                n_r    <= bus.call_count;
                runs_r <= {CNT_W{1'b0}};
            end else if ((state_r == WAIT) && rise_s) begin
                n_r    <= n_r;
                runs_r <= runs_r + CNT_W'(1);
            end else begin
                n_r    <= n_r;
                runs_r <= runs_r;
            end
        end
    end

`ifdef TOY_HOST_CALLER_WATCHDOG_EN
    // Timeout flag, latched on RESP entry and held while the response is pending
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_timeout_r <= 1'b0;
        end else if (next_s != RESP) begin
            done_timeout_r <= 1'b0;
        end else if (state_r == RESP) begin
            done_timeout_r <= done_timeout_r;
        end else begin
            done_timeout_r <= timeout_s;
        end
    end

    assign bus.done_timeout = done_timeout_r;
`endif

    assign bus.call_ready  = (state_r == IDLE);
    assign bus.start       = start_r;
    assign bus.done_valid  = done_valid_r;
    assign bus.done_runs   = runs_r;
    assign bus.done_cycles = cyc_cnt_s;
    assign bus.proto_err   = proto_err_r;

endmodule

// File: tb/tb_toy_host_caller.sv
// -----------------------------------------------------------------------------
// tb_toy_host_caller
// Self-checking bench for toy_host_caller (CNT_W=8, CYC_W=8 so saturation is
// reachable). A kernel model answers start with a configurable stall and
// finish delay/hold; expected results come from run arithmetic and from
// cycle timestamps of the kernel model.
// -----------------------------------------------------------------------------
module tb_toy_host_caller;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    toy_host_caller_if #(.CNT_W(8), .CYC_W(8)) bus ();

    toy_host_caller #(
        .CNT_W(8),
        .CYC_W(8)
`ifdef TOY_HOST_CALLER_WATCHDOG_EN
        ,
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int n;
        int st;
        int dl;
        int hd;
        int rd;
        int exp_runs;
        int exp_cyc;
    } vec_t;

    vec_t vecs[7];

    int n_cmp = 0;
    int n_bad = 0;

    // kernel model state
    int  cyc;
    int  stall_cfg, fin_delay, fin_hold;
    int  stall_left;
    int  fin_at;
    bit  fin_force;
    int  accepts;
    int  start_hi;
    int  last_fin;
    int  cmd_cyc;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock: DUT samples, then the kernel model reacts to what was seen
    task automatic step();
        logic p_start, p_stall, p_cv, p_cr;
        p_start = bus.start;
        p_stall = bus.callee_stall;
        p_cv    = bus.call_valid;
        p_cr    = bus.call_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (p_start) start_hi++;
        if (p_cv && p_cr) cmd_cyc = cyc - 1;
        if (p_start && p_stall && stall_left > 0) stall_left--;
        if (p_start && !p_stall) begin
            accepts++;
            fin_at   = cyc - 1 + fin_delay;
            last_fin = fin_at;
        end
        if (bus.start && !p_start) stall_left = stall_cfg;
        bus.callee_stall = (stall_left > 0);
        bus.finish       = fin_force || (cyc >= fin_at && cyc < fin_at + fin_hold);
    endtask

    task automatic do_call(input int n, input int st, input int dl, input int hd,
                           input int rd, input int exp_runs, input int exp_cyc,
                           input string tag);
        int t, cv, vcount, busy_rdy, stab_err, ts;
        logic [7:0] r0, c0;
        stall_cfg = st; fin_delay = dl; fin_hold = hd;
        fin_at = -1000; accepts = 0; start_hi = 0; last_fin = -1; cmd_cyc = -1;
        bus.finish = 1'b0;
        bus.done_ready = (rd == 0);
        bus.call_count = n[7:0];
        bus.call_valid = 1'b1;
        t = 0;
        while (cmd_cyc < 0 && t < 50) begin step(); t++; end
        bus.call_valid = 1'b0;
        busy_rdy = 0; t = 0;
        while (!bus.done_valid && t < 3000) begin
            if (bus.call_ready) busy_rdy++;
            step(); t++;
        end
        chk({tag, ".valid_seen"}, bus.done_valid, 1);
        cv = cyc;
        r0 = bus.done_runs;
        c0 = bus.done_cycles;
        ts = (n == 0) ? 0 : last_fin - cmd_cyc;
        if (ts > 255) ts = 255;
        chk({tag, ".runs"}, r0, exp_runs);
        chk({tag, ".cycles"}, c0, exp_cyc);
        chk({tag, ".cycles_ts"}, c0, ts);
        chk({tag, ".accepts"}, accepts, n);
        chk({tag, ".start_cycles"}, start_hi, n * (st + 1));
        chk({tag, ".latency"}, cv, (n == 0) ? cmd_cyc + 1 : last_fin + 1);
        chk({tag, ".busy_ready"}, busy_rdy, 0);
`ifdef TOY_HOST_CALLER_WATCHDOG_EN
        chk({tag, ".timeout"}, bus.done_timeout, 0);
`endif
        vcount = 0; stab_err = 0; t = 0;
        while (bus.done_valid && t < 50) begin
            if (bus.done_runs !== r0 || bus.done_cycles !== c0) stab_err++;
            bus.done_ready = ((cyc - cv) >= rd);
            vcount++;
            step(); t++;
        end
        bus.done_ready = 1'b0;
        chk({tag, ".valid_len"}, vcount, rd + 1);
        chk({tag, ".stable"}, stab_err, 0);
        chk({tag, ".idle_ready"}, bus.call_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int t, n, st, dl, hd, rd, ec;
        reset_n = 1'b0;
        bus.call_valid = 1'b0; bus.call_count = 8'd0; bus.callee_stall = 1'b0;
        bus.finish = 1'b0; bus.done_ready = 1'b0;
        cyc = 0; stall_cfg = 0; fin_delay = 1; fin_hold = 1; stall_left = 0;
        fin_at = -1000; fin_force = 1'b0; accepts = 0; start_hi = 0;
        last_fin = -1; cmd_cyc = -1;

        //            n   st  dl  hd  rd  runs cycles
        vecs[0] = '{  3,  0,  5,  1,  1,   3,  18};  // 3 x (1 START + 5 WAIT)
        vecs[1] = '{  1,  4,  2,  1,  0,   1,   7};  // start held 5 cycles
        vecs[2] = '{  0,  0,  3,  1,  0,   0,   0};  // no run, ready tied high
        vecs[3] = '{  2,  1,  3,  3,  2,   2,  10};  // held finish counts once
        vecs[4] = '{  4,  0,  1,  1,  0,   4,   8};  // shortest runs
        vecs[5] = '{  3, 80,  5,  1,  1,   3, 255};  // 258 saturates
        vecs[6] = '{255,  0,  1,  1,  3, 255, 255};  // max count, 510 saturates

        repeat (3) @(posedge clk);
        #1;
        chk("rst.start", bus.start, 0);
        chk("rst.done_valid", bus.done_valid, 0);
        chk("rst.done_runs", bus.done_runs, 0);
        chk("rst.done_cycles", bus.done_cycles, 0);
        chk("rst.proto_err", bus.proto_err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.call_ready", bus.call_ready, 1);

        for (int i = 0; i < 7; i++) begin
            do_call(vecs[i].n, vecs[i].st, vecs[i].dl, vecs[i].hd, vecs[i].rd,
                    vecs[i].exp_runs, vecs[i].exp_cyc, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            n  = $urandom_range(0, 6);
            st = $urandom_range(0, 3);
            dl = $urandom_range(1, 8);
            hd = $urandom_range(1, (dl < 3) ? dl : 3);
            rd = $urandom_range(0, 3);
            ec = n * (st + 1 + dl);
            if (ec > 255) ec = 255;
            do_call(n, st, dl, hd, rd, n, ec, $sformatf("rnd%0d", i));
        end
        chk("clean.proto_err", bus.proto_err, 0);

        // spurious finish while idle, then a held finish in WAIT
        fin_force = 1'b1; bus.finish = 1'b1;
        step();
        fin_force = 1'b0;
        step();
        step();
        chk("spur.proto_err", bus.proto_err, 1);
        chk("spur.call_ready", bus.call_ready, 1);
        chk("spur.done_valid", bus.done_valid, 0);
        do_call(1, 0, 4, 3, 0, 1, 5, "held");
        chk("held.proto_err", bus.proto_err, 1);

        // reset while the second run's start is pending
        stall_cfg = 3; fin_delay = 20; fin_hold = 1; accepts = 0; fin_at = -1000;
        bus.call_count = 8'd2; bus.call_valid = 1'b1;
        step();
        bus.call_valid = 1'b0;
        t = 0;
        while (!(accepts == 1 && bus.start) && t < 100) begin step(); t++; end
        chk("mid.reach_start2", (accepts == 1 && bus.start), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid.start", bus.start, 0);
        chk("mid.done_valid", bus.done_valid, 0);
        chk("mid.proto_err", bus.proto_err, 0);
        chk("mid.done_runs", bus.done_runs, 0);
        chk("mid.done_cycles", bus.done_cycles, 0);
        stall_left = 0; fin_at = -1000; fin_force = 1'b0;
        bus.finish = 1'b0; bus.callee_stall = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid.call_ready", bus.call_ready, 1);
        do_call(2, 1, 3, 1, 1, 2, 10, "after_rst");

`ifdef TOY_HOST_CALLER_WATCHDOG_EN
        // kernel never finishes: 1 START + 16 WAIT cycles, then timeout response
        stall_cfg = 0; fin_delay = 1000000; fin_hold = 1; accepts = 0;
        fin_at = -1000; cmd_cyc = -1;
        bus.done_ready = 1'b0; bus.call_count = 8'd2; bus.call_valid = 1'b1;
        step();
        bus.call_valid = 1'b0;
        t = 0;
        while (!bus.done_valid && t < 100) begin step(); t++; end
        chk("wd.valid_seen", bus.done_valid, 1);
        chk("wd.latency", cyc - cmd_cyc, 18);
        chk("wd.timeout", bus.done_timeout, 1);
        chk("wd.runs", bus.done_runs, 0);
        chk("wd.cycles", bus.done_cycles, 17);
        chk("wd.proto_err", bus.proto_err, 1);
        chk("wd.accepts", accepts, 1);
        bus.done_ready = 1'b1;
        step();
        bus.done_ready = 1'b0;
        chk("wd.valid_drop", bus.done_valid, 0);
        chk("wd.timeout_drop", bus.done_timeout, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
